// File: rtl/cascade_timer_pkg.sv
// Shared types and helpers for the cascaded modulo-stage timer.
package cascade_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } ct_state_t;

  typedef enum logic [1:0] {
    M_CLOCK     = 2'b00,
    M_STOPWATCH = 2'b01,
    M_COUNTDOWN = 2'b10,
    M_HOLD      = 2'b11
  } ct_mode_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int numofbits(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/cascade_timer_if.sv
// Control/status bundle between the cascade timer and its controller.
interface cascade_timer_if #(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_W    = 6
);
  import cascade_timer_pkg::*;

  localparam int SEL_W = numofbits(NUM_STAGES);

  ct_mode_t                    rezhim;
  logic                        run;
  logic                        timer_reset;
  logic                        load_stb;
  logic [SEL_W-1:0]            load_sel;
  logic [STAGE_W-1:0]          load_val;
  logic [NUM_STAGES*STAGE_W-1:0] data;
  logic                        carry_out;
  logic                        done;
  logic                        expired;

  modport master (
    output rezhim, run, timer_reset, load_stb, load_sel, load_val,
    input  data, carry_out, done, expired
  );

  modport slave (
    input  rezhim, run, timer_reset, load_stb, load_sel, load_val,
    output data, carry_out, done, expired
  );

endinterface

// File: rtl/cascade_timer_mod_stage.sv
// One modulo-MOD counting stage: up/down step with wrap, clamped load, terminal flag.
module mod_stage #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         dir_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] value_o,
  output logic         at_term_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = (load_val_i > LAST) ? LAST : load_val_i;
    end else if (en_i) begin
      if (dir_i) value_d = (value_q == '0) ? LAST : value_q - W'(1);
      else       value_d = (value_q == LAST) ? '0 : value_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value_o   = value_q;
  assign at_term_o = dir_i ? (value_q == '0) : (value_q == LAST);

endmodule

// File: rtl/cascade_timer.sv
// N-stage cascaded time counter with prescaler: clock, stopwatch, countdown and hold modes.
module cascade_timer
  import cascade_timer_pkg::*;
#(
  parameter int NUM_STAGES            = 3,
  parameter int STAGE_W               = 6,
  parameter int STAGE_MOD [NUM_STAGES] = '{60, 60, 24},
  parameter int TICK_DIV              = 50000000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  cascade_timer_if.slave bus
);

  localparam int SEL_W = numofbits(NUM_STAGES);
  localparam int PRE_W = numofbits(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  ct_state_t  state_q, state_d;
  ct_mode_t   mode_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic carry_q, carry_d, done_q, done_d, expired_q;

  logic [STAGE_W-1:0] value [NUM_STAGES];
  logic [NUM_STAGES-1:0] at_term, stage_en, stage_load, nonzero;
  logic [NUM_STAGES:0]   low_term;
  logic [NUM_STAGES*STAGE_W-1:0] data_w;

  logic load_ok, mode_chg, tick, count_tick, dir_down;
  logic all_term, one_left, step;

  assign load_ok  = bus.load_stb && ({1'b0, bus.load_sel} < (SEL_W + 1)'(NUM_STAGES));
  assign mode_chg = (bus.rezhim != mode_q);
  assign dir_down = (bus.rezhim == M_COUNTDOWN);
  assign tick     = (pre_q == PRE_LAST) && (state_q == RUN);
  // Higher-priority events (clear, load, mode change) swallow a coincident tick.
  assign count_tick = tick && bus.run && (bus.rezhim != M_HOLD) &&
                      !bus.timer_reset && !load_ok && !mode_chg;

  assign low_term[0] = 1'b1;
  assign all_term    = low_term[NUM_STAGES];
  assign one_left    = (value[0] == STAGE_W'(1)) && !(|(nonzero >> 1));

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    assign low_term[gi+1]  = low_term[gi] & at_term[gi];
    assign stage_en[gi]    = step & low_term[gi];
    assign stage_load[gi]  = load_ok && (bus.load_sel == SEL_W'(gi));
    assign nonzero[gi]     = |value[gi];

    mod_stage #(
      .MOD (STAGE_MOD[gi]),
      .W   (STAGE_W)
    ) u_stage (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (bus.timer_reset),
      .en_i       (stage_en[gi]),
      .dir_i      (dir_down),
      .load_i     (stage_load[gi]),
      .load_val_i (bus.load_val),
      .value_o    (value[gi]),
      .at_term_o  (at_term[gi])
    );
  end

  always_comb begin
    data_w = '0;
    for (int i = 0; i < NUM_STAGES; i++) data_w[i*STAGE_W +: STAGE_W] = value[i];
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    step    = 1'b0;
    carry_d = 1'b0;
    done_d  = 1'b0;

    unique case (bus.rezhim)
      M_CLOCK: begin
        step    = count_tick;
        carry_d = count_tick && all_term;
      end
      M_STOPWATCH: begin
        step   = count_tick && !all_term;
        done_d = count_tick && all_term;
      end
      M_COUNTDOWN: begin
        // all_term here means every stage is already zero: hold and flag.
        step   = count_tick && !all_term;
        done_d = count_tick && (all_term || one_left);
      end
      default: ;
    endcase

    if (bus.timer_reset || load_ok || mode_chg) pre_d = '0;
    else if (state_q == RUN) pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);

    if (bus.timer_reset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bus.run && bus.rezhim != M_HOLD) state_d = RUN;
        RUN: begin
          if (!bus.run || bus.rezhim == M_HOLD) state_d = IDLE;
          else if (done_d)                       state_d = EXPIRED;
        end
        EXPIRED: if (load_ok || mode_chg) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mode_q    <= M_CLOCK;
      pre_q     <= '0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= bus.rezhim;
      pre_q     <= pre_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
      expired_q <= (state_d == EXPIRED);
    end
  end

  assign bus.data      = data_w;
  assign bus.carry_out = carry_q;
  assign bus.done      = done_q;
  assign bus.expired   = expired_q;

endmodule

// File: tb/tb_cascade_timer.sv
// Scoreboard bench for cascade_timer with 24h clock stages and a divide-by-4 prescaler.
module tb_cascade_timer;
  import cascade_timer_pkg::*;

  localparam int NS = 3;
  localparam int SW = 6;
  localparam int DW = NS * SW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          carry;
    logic          done;
    logic          expired;
    int            gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t  exp_q[$];
  string name_q[$];

  cascade_timer_if #(.NUM_STAGES(NS), .STAGE_W(SW)) tif ();

  cascade_timer #(
    .NUM_STAGES (NS),
    .STAGE_W    (SW),
    .STAGE_MOD  ('{60, 60, 24}),
    .TICK_DIV   (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (tif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  task automatic ev(input logic [DW-1:0] d, input logic c, input logic dn, input logic e,
                    input int gap, input string nm);
    exp_t x;
    x.data = d; x.carry = c; x.done = dn; x.expired = e; x.gap = gap;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ld(input int sel, input int val);
    tif.load_sel = 2'(sel);
    tif.load_val = 6'(val);
    tif.load_stb = 1'b1;
    step(1);
    tif.load_stb = 1'b0;
  endtask

  task automatic treset();
    tif.timer_reset = 1'b1;
    step(1);
    tif.timer_reset = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, expv);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  task automatic drain(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_%s: %0d events still pending, required 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // Monitor: any data change, pulse, or expired edge is one observed event.
  initial begin : monitor
    logic [DW-1:0] prev_data;
    logic          prev_exp;
    int            last_ev;
    exp_t          e;
    string         nm;
    prev_data = '0;
    prev_exp  = 1'b0;
    last_ev   = 0;
    forever begin
      @(negedge clk);
      if (tif.data !== prev_data || tif.carry_out === 1'b1 || tif.done === 1'b1 ||
          tif.expired !== prev_exp) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_event: got data=%h carry=%b done=%b expired=%b, required no event",
                   tif.data, tif.carry_out, tif.done, tif.expired);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if ({tif.data, tif.carry_out, tif.done, tif.expired} !== {e.data, e.carry, e.done, e.expired}) begin
            fails++;
            $display("FAIL %s: got data=%h carry=%b done=%b expired=%b, required data=%h carry=%b done=%b expired=%b",
                     nm, tif.data, tif.carry_out, tif.done, tif.expired, e.data, e.carry, e.done, e.expired);
          end else begin
            $display("ok   %s data=%h carry=%b done=%b expired=%b", nm, tif.data, tif.carry_out, tif.done, tif.expired);
          end
          if (e.gap >= 0) begin
            checks++;
            if (cyc - last_ev != e.gap) begin
              fails++;
              $display("FAIL %s_gap: got %0d cycles since previous event, required %0d", nm, cyc - last_ev, e.gap);
            end
          end
        end
        last_ev = cyc;
      end
      prev_data = tif.data;
      prev_exp  = tif.expired;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    tif.rezhim      = M_CLOCK;
    tif.run         = 1'b0;
    tif.timer_reset = 1'b0;
    tif.load_stb    = 1'b0;
    tif.load_sel    = '0;
    tif.load_val    = '0;
    step(3);
    chk("reset_data", 32'(tif.data), 32'(hms(0, 0, 0)));
    chk("reset_flags", {29'd0, tif.carry_out, tif.done, tif.expired}, 32'd0);
    rst_n = 1'b1;
    step(1);

    // Clock mode wrap from 23:59:59
    ev(hms(0, 0, 59), 0, 0, 0, -1, "ld_sec");   ld(0, 59);
    ev(hms(0, 59, 59), 0, 0, 0, 1, "ld_min");   ld(1, 59);
    ev(hms(23, 59, 59), 0, 0, 0, 1, "ld_hr");   ld(2, 23);
    ev(hms(0, 0, 0), 1, 0, 0, 5, "clock_wrap");
    ev(hms(0, 0, 1), 0, 0, 0, 4, "clock_cont1");
    ev(hms(0, 0, 2), 0, 0, 0, 4, "clock_cont2");
    tif.run = 1'b1;
    drain(40, "clock");
    tif.run = 1'b0;
    step(2);

    // Countdown: borrow, reach zero, then start from zero
    ev(hms(0, 0, 0), 0, 0, 0, -1, "cd_clear");  treset();
    tif.rezhim = M_COUNTDOWN;
    step(1);
    ev(hms(0, 1, 0), 0, 0, 0, -1, "cd_ld_min"); ld(1, 1);
    ev(hms(0, 0, 59), 0, 0, 0, 5, "cd_borrow");
    ev(hms(0, 0, 58), 0, 0, 0, 4, "cd_second");
    tif.run = 1'b1;
    drain(30, "cd_borrow");
    tif.run = 1'b0;
    step(1);
    ev(hms(0, 0, 2), 0, 0, 0, -1, "cd_ld_2");   ld(0, 2);
    ev(hms(0, 0, 1), 0, 0, 0, 5, "cd_one");
    ev(hms(0, 0, 0), 0, 1, 1, 4, "cd_zero");
    tif.run = 1'b1;
    drain(30, "cd_zero");
    step(20);
    chk("cd_hold_data", 32'(tif.data), 32'(hms(0, 0, 0)));
    chk("cd_hold_expired", 32'(tif.expired), 32'd1);
    tif.run = 1'b0;
    step(1);
    ev(hms(0, 0, 0), 0, 0, 0, -1, "cd_treset_clears"); treset();
    ev(hms(0, 0, 0), 0, 1, 1, 5, "cd_from_zero");
    tif.run = 1'b1;
    drain(30, "cd_from_zero");
    tif.run = 1'b0;
    step(1);
    ev(hms(0, 0, 0), 0, 0, 0, -1, "mode_change_clears");
    tif.rezhim = M_CLOCK;
    drain(5, "mode_change");

    // Load clamp and out-of-range select
    ev(hms(0, 59, 0), 0, 0, 0, -1, "clamp_min"); ld(1, 63);
    ld(3, 5);
    step(3);
    chk("sel_ignored", 32'(tif.data), 32'(hms(0, 59, 0)));
    ev(hms(23, 59, 0), 0, 0, 0, -1, "clamp_hr"); ld(2, 30);
    drain(5, "clamp");

    // Same-cycle conflicts
    ev(hms(0, 0, 0), 0, 0, 0, -1, "treset_beats_load");
    tif.load_sel = 2'd0; tif.load_val = 6'd7;
    tif.load_stb = 1'b1; tif.timer_reset = 1'b1;
    step(1);
    tif.load_stb = 1'b0; tif.timer_reset = 1'b0;
    ev(hms(0, 0, 10), 0, 0, 0, 5, "load_on_tick");
    ev(hms(0, 0, 11), 0, 0, 0, 4, "tick_after_load");
    tif.run = 1'b1;
    step(4);
    ld(0, 10);
    drain(20, "conflict");
    tif.run = 1'b0;
    step(1);

    // Hold: no counting, load still accepted
    tif.rezhim = M_HOLD;
    step(1);
    tif.run = 1'b1;
    step(12);
    ev(hms(0, 0, 30), 0, 0, 0, -1, "hold_load"); ld(0, 30);
    drain(5, "hold");
    tif.run = 1'b0;

    // Stopwatch saturation at 23:59:59
    tif.rezhim = M_STOPWATCH;
    step(1);
    ev(hms(23, 0, 30), 0, 0, 0, -1, "sw_ld_hr");   ld(2, 23);
    ev(hms(23, 59, 30), 0, 0, 0, 1, "sw_ld_min");  ld(1, 59);
    ev(hms(23, 59, 58), 0, 0, 0, 1, "sw_ld_sec");  ld(0, 58);
    ev(hms(23, 59, 59), 0, 0, 0, 5, "sw_to_59");
    ev(hms(23, 59, 59), 0, 1, 1, 4, "sw_saturate");
    tif.run = 1'b1;
    drain(30, "stopwatch");
    step(12);
    chk("sw_expired_level", 32'(tif.expired), 32'd1);
    tif.run = 1'b0;
    step(1);
    ev(hms(23, 59, 59), 0, 0, 0, -1, "sw_mode_exit");
    tif.rezhim = M_CLOCK;
    drain(5, "sw_exit");

    // Asynchronous reset mid-count, then resume from zero
    ev(hms(5, 59, 59), 0, 0, 0, -1, "ar_ld_hr");  ld(2, 5);
    ev(hms(5, 10, 59), 0, 0, 0, 1, "ar_ld_min");  ld(1, 10);
    ev(hms(5, 10, 20), 0, 0, 0, 1, "ar_ld_sec");  ld(0, 20);
    ev(hms(5, 10, 21), 0, 0, 0, 5, "ar_count1");
    ev(hms(5, 10, 22), 0, 0, 0, 4, "ar_count2");
    tif.run = 1'b1;
    drain(30, "pre_reset");
    step(1);
    ev(hms(0, 0, 0), 0, 0, 0, -1, "async_reset");
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_data", 32'(tif.data), 32'(hms(0, 0, 0)));
    chk("async_flags", {29'd0, tif.carry_out, tif.done, tif.expired}, 32'd0);
    step(3);
    rst_n = 1'b1;
    ev(hms(0, 0, 1), 0, 0, 0, -1, "resume1");
    ev(hms(0, 0, 2), 0, 0, 0, 4, "resume2");
    drain(30, "resume");
    tif.run = 1'b0;

    step(10);
    drain(5, "final");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
